// File: rtl/pdm_window_frontend.sv
`default_nettype none
// ============================================================================
// Module   : pdm_window_frontend
// Purpose  : PDM microphone front end. Generates the mic clock, synchronises
//            the PDM bitstream, keeps a sliding-window ones-count and emits
//            a strobed window sum, centre-offset amplitude and peak value.
// Ports    : clk_i          system clock (rising edge)
//            rst_ni         asynchronous active-low reset
//            clr_i          synchronous clear of window/counters/peak
//            m_clk_o        microphone clock
//            m_lrsel_o      L/R select (constant 0)
//            m_data_i       raw PDM data (asynchronous to clk_i)
//            sample_valid_o one-cycle strobe: sum/amp/peak updated
//            full_o         window holds WINDOW real samples
//            sum_o          ones-count over last WINDOW samples
//            amp_o          |sum_o - WINDOW/2|
//            peak_o         peak-hold of amp_o
// Options  : define PDM_PEAK_HOLD_EN to build the hold/decay peak tracker;
//            otherwise peak_o mirrors the amp_o register.
// Revision : 1.0 - initial release
// ============================================================================
module pdm_window_frontend #(
  parameter int CLK_DIV = 25,
  parameter int WINDOW  = 128,
  parameter int HOLD    = 4096,
  parameter int DECAY   = 256,
  localparam int SW     = $clog2(WINDOW) + 1,
  localparam int AW     = $clog2(WINDOW)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  output logic          m_clk_o,
  output logic          m_lrsel_o,
  input  logic          m_data_i,
  output logic          sample_valid_o,
  output logic          full_o,
  output logic [SW-1:0] sum_o,
  output logic [AW-1:0] amp_o,
  output logic [AW-1:0] peak_o
);

  localparam int DW     = $clog2(CLK_DIV);
  localparam int c_HALF = WINDOW / 2;

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // ---------------- clock divider ----------------
  logic [DW-1:0] div_cnt_q;
  logic          m_clk_q;
  logic          div_tc;
  logic          sample_stb;

  assign div_tc     = (div_cnt_q == DW'(CLK_DIV - 1));
  // Sample on the cycle the divider drives m_clk 1->0.
  assign sample_stb = div_tc & m_clk_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      m_clk_q   <= 1'b0;
    end else if (div_tc) begin
      div_cnt_q <= '0;
      m_clk_q   <= ~m_clk_q;
    end else begin
      div_cnt_q <= div_cnt_q + DW'(1);
    end
  end

  assign m_clk_o   = m_clk_q;
  assign m_lrsel_o = 1'b0;

  // ---------------- synchroniser ----------------
  logic [1:0] sync_q;
  logic       d_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[0], m_data_i};
  end

  assign d_sync = sync_q[1];

  // ---------------- window datapath ----------------
  logic [WINDOW-1:0] buf_q;
  logic [AW-1:0]     wp_q;
  logic [AW-1:0]     fill_q;
  logic [SW-1:0]     sum_q;
  logic [AW-1:0]     amp_q;
  logic              valid_q;
  logic [SW-1:0]     sum_d;
  logic [AW-1:0]     amp_d;

  // Oldest bit leaves, newest enters; range stays within 0..WINDOW.
  assign sum_d = sum_q - SW'(buf_q[wp_q]) + SW'(d_sync);

  always_comb begin
    amp_d = '0;
    if (sum_d >= SW'(c_HALF)) amp_d = AW'(sum_d - SW'(c_HALF));
    else                      amp_d = AW'(SW'(c_HALF) - sum_d);
  end

  // ---------------- FSM ----------------
  logic [0:0] state_q;
  logic [0:0] state_d;
  logic       fill_last;
  logic       emit_d;

  assign fill_last = (state_q == S_FILL) && (fill_q == AW'(WINDOW - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_FILL;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr_i)                        state_d = S_FILL;
    else if (sample_stb && fill_last) state_d = S_RUN;
  end

  always_comb begin
    full_o = (state_q == S_RUN);
    // The WINDOW-th sample already produces the first valid pulse.
    emit_d = sample_stb & ~clr_i & ((state_q == S_RUN) | fill_last);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q   <= '0;
      wp_q    <= '0;
      fill_q  <= '0;
      sum_q   <= '0;
      amp_q   <= '0;
      valid_q <= 1'b0;
    end else if (clr_i) begin
      // Clear wins over a coincident sample strobe.
      buf_q   <= '0;
      wp_q    <= '0;
      fill_q  <= '0;
      sum_q   <= '0;
      amp_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= emit_d;
      if (sample_stb) begin
        buf_q[wp_q] <= d_sync;
        wp_q        <= wp_q + AW'(1);
        sum_q       <= sum_d;
        amp_q       <= amp_d;
        if (state_q == S_FILL) fill_q <= fill_q + AW'(1);
      end
    end
  end

  assign sample_valid_o = valid_q;
  assign sum_o          = sum_q;
  assign amp_o          = amp_q;

  // ---------------- peak tracker ----------------
`ifdef PDM_PEAK_HOLD_EN
  localparam int HW  = $clog2(HOLD + 1);
  localparam int DCW = $clog2(DECAY + 1);

  logic [AW-1:0]  peak_q;
  logic [HW-1:0]  hold_q;
  logic [DCW-1:0] dec_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      peak_q <= '0;
      hold_q <= '0;
      dec_q  <= '0;
    end else if (clr_i) begin
      peak_q <= '0;
      hold_q <= '0;
      dec_q  <= '0;
    end else if (emit_d) begin
      if (amp_d > peak_q) begin
        peak_q <= amp_d;
        hold_q <= HW'(HOLD);
        dec_q  <= '0;
      end else if (hold_q != '0) begin
        hold_q <= hold_q - HW'(1);
      end else if (dec_q == DCW'(DECAY - 1)) begin
        dec_q  <= '0;
        // amp_d <= peak_q here, so peak-1 only loses to amp when they are equal.
        peak_q <= (peak_q > amp_d) ? peak_q - AW'(1) : amp_d;
      end else begin
        dec_q  <= dec_q + DCW'(1);
      end
    end
  end

  assign peak_o = peak_q;
`else
  assign peak_o = amp_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pdm_window_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdm_window_frontend
// Purpose  : Self-checking bench for pdm_window_frontend. A queue-based
//            window model predicts sum/amp/peak after every sample; the mic
//            clock is predicted from the cycle count since reset release.
//            Reduced parameters keep the hold/decay run short.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pdm_window_frontend;

  localparam int CD    = 4;
  localparam int W     = 32;
  localparam int HOLD  = 64;
  localparam int DECAY = 8;
  localparam int SW    = $clog2(W) + 1;
  localparam int AW    = $clog2(W);
  localparam int HALF  = W / 2;
  localparam int PER   = 2 * CD;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clr_i = 1'b0;
  logic          m_data_i = 1'b0;
  logic          m_clk_o;
  logic          m_lrsel_o;
  logic          sample_valid_o;
  logic          full_o;
  logic [SW-1:0] sum_o;
  logic [AW-1:0] amp_o;
  logic [AW-1:0] peak_o;

  pdm_window_frontend #(
    .CLK_DIV(CD), .WINDOW(W), .HOLD(HOLD), .DECAY(DECAY)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr_i),
    .m_clk_o(m_clk_o), .m_lrsel_o(m_lrsel_o), .m_data_i(m_data_i),
    .sample_valid_o(sample_valid_o), .full_o(full_o),
    .sum_o(sum_o), .amp_o(amp_o), .peak_o(peak_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int n = 0;           // rising edges since reset release
  bit win[$];          // last min(fill, W) captured bits
  int fill = 0;
  int m_sum = 0, m_amp = 0, m_peak = 0, hold = 0, dec = 0;
  int m_valid = 0, m_full = 0;
  bit cur_bit = 1'b0;  // bit currently presented on m_data_i
  int mode = 0;        // 0: zeros, 1: ones, 2: alternating, 3: random
  bit alt = 1'b0;
  bit last_smp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit gen_bit();
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: begin alt = ~alt; return alt; end
      default: return bit'($urandom % 2);
    endcase
  endfunction

  task automatic model_clear();
    win.delete();
    fill = 0; m_sum = 0; m_amp = 0; m_peak = 0;
    hold = 0; dec = 0; m_valid = 0; m_full = 0;
  endtask

  // One clock cycle: update the model for this edge, then check all outputs.
  task automatic tick();
    bit smp;
    @(posedge clk);
    n++;
    smp = (n % PER == 0);
    last_smp = smp;
    if (clr_i) begin
      model_clear();
    end else if (smp) begin
      win.push_back(cur_bit);
      if (win.size() > W) void'(win.pop_front());
      fill++;
      m_sum = 0;
      foreach (win[i]) m_sum += int'(win[i]);
      m_amp   = (m_sum >= HALF) ? m_sum - HALF : HALF - m_sum;
      m_full  = (fill >= W);
      m_valid = m_full;
`ifdef PDM_PEAK_HOLD_EN
      if (m_valid != 0) begin
        if (m_amp > m_peak) begin
          m_peak = m_amp; hold = HOLD; dec = 0;
        end else if (hold > 0) begin
          hold--;
        end else begin
          dec++;
          if (dec == DECAY) begin
            dec = 0;
            m_peak = (m_peak - 1 > m_amp) ? m_peak - 1 : m_amp;
          end
        end
      end
`endif
    end else begin
      m_valid = 0;
    end
`ifndef PDM_PEAK_HOLD_EN
    m_peak = m_amp;
`endif
    #1;
    clr_i = 1'b0;
    chk("m_clk", m_clk_o, (n / CD) % 2);
    chk("lrsel", m_lrsel_o, 0);
    chk("valid", sample_valid_o, m_valid);
    chk("full", full_o, m_full);
    if (m_full != 0 || fill == 0) begin
      chk("sum", sum_o, m_sum);
      chk("amp", amp_o, m_amp);
`ifndef PDM_PEAK_HOLD_EN
      chk("peak", peak_o, m_peak);
`endif
    end
`ifdef PDM_PEAK_HOLD_EN
    chk("peak", peak_o, m_peak);
`endif
    if (smp) begin
      cur_bit  = gen_bit();
      m_data_i = cur_bit;
    end
  endtask

  task automatic run_samples(input int k);
    int cnt = 0;
    while (cnt < k) begin
      tick();
      if (last_smp) cnt++;
    end
  endtask

  initial begin
    // reset phase
    mode = 1; cur_bit = 1'b1; m_data_i = 1'b1;
    rst_ni = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_mclk", m_clk_o, 0);
      chk("rst_valid", sample_valid_o, 0);
      chk("rst_full", full_o, 0);
      chk("rst_sum", sum_o, 0);
      chk("rst_amp", amp_o, 0);
      chk("rst_peak", peak_o, 0);
    end
    rst_ni = 1'b1;
    n = 0;

    // constant 1: first valid with the W-th sample
    run_samples(W);
    chk("first_valid", sample_valid_o, 1);
    chk("first_full", full_o, 1);
    chk("first_sum", sum_o, W);
    chk("first_amp", amp_o, HALF);
    chk("first_peak", peak_o, HALF);

    // alternating: sum settles at W/2, peak holds then decays to 0
    mode = 2;
    run_samples(HOLD + DECAY * HALF + 20);
    chk("alt_sum", sum_o, HALF);
    chk("alt_amp", amp_o, 0);
    chk("alt_peak", peak_o, 0);

    // full window of ones then zeros: sum ramps down by 1 per sample
    mode = 1;
    run_samples(W + 1);
    chk("ones_sum", sum_o, W);
    mode = 0;
    run_samples(W + 8);
    chk("zeros_sum", sum_o, 0);
    chk("zeros_amp", amp_o, HALF);

    // random data
    mode = 3;
    run_samples(100);

    // clear coincident with a sample strobe
    while ((n + 1) % PER != 0) tick();
    clr_i = 1'b1;
    tick();
    chk("clr_valid", sample_valid_o, 0);
    chk("clr_sum", sum_o, 0);
    chk("clr_peak", peak_o, 0);
    chk("clr_full", full_o, 0);
    run_samples(W - 1);
    chk("refill_nofull", full_o, 0);
    run_samples(1);
    chk("refill_valid", sample_valid_o, 1);
    chk("refill_full", full_o, 1);

    // clear between samples
    mode = 1;
    run_samples(5);
    tick(); tick();
    clr_i = 1'b1;
    tick();
    chk("clr2_full", full_o, 0);
    chk("clr2_sum", sum_o, 0);
    mode = 3;
    run_samples(W + 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pdm_window_frontend.md
Name: pdm_window_frontend

Overview:
- Front-end stage between the on-board PDM microphone and the level/clap displays.
- Generates the microphone clock and samples the PDM bitstream in the system clock domain.
- Maintains a sliding-window ones-count over the last WINDOW bits.
- Delivers a strobed window sum, centre-offset amplitude and decaying peak-hold value to downstream LED-bar, 7-segment and clap-detect consumers.

Parameters:
- CLK_DIV, 25: clk_i cycles per m_clk_o half-period (100 MHz -> 2 MHz mic clock); must be >= 2.
- WINDOW, 128: sliding-window length in PDM samples; power of two, >= 4.
- HOLD, 4096: samples the peak is held before decay starts.
- DECAY, 256: samples per 1-LSB peak decrement once hold has expired.
- Derived, not overridable: SW = $clog2(WINDOW)+1; AW = $clog2(WINDOW).

Ports:
- clk_i, input, 1: system clock; all logic on rising edge.
- rst_ni, input, 1: reset, asynchronous assert, active-low.
- clr_i, input, 1: synchronous clear of window, counters and peak; mic clock keeps running.
- m_clk_o, output, 1: microphone clock.
- m_lrsel_o, output, 1: L/R select, constant 0.
- m_data_i, input, 1: raw PDM data from microphone; asynchronous to clk_i.
- sample_valid_o, output, 1: one-cycle strobe; sum_o/amp_o/peak_o updated this cycle.
- full_o, output, 1: window holds WINDOW real samples.
- sum_o, output, SW: ones-count over last WINDOW samples, range 0..WINDOW.
- amp_o, output, AW: |sum_o - WINDOW/2|, range 0..WINDOW/2.
- peak_o, output, AW: peak-hold of amp_o.

Behaviour:
- Clock and reset interface: one clock (clk_i); reset rst_ni is asynchronous and active-low. All registers and outputs are 0 during reset, including m_clk_o, the window buffer and the FSM (FILL).
- Divider: counter 0..CLK_DIV-1, toggles m_clk_o at terminal count. First toggle occurs CLK_DIV cycles after rst_ni release. Period is 2*CLK_DIV cycles, 50% duty.
- Synchroniser: m_data_i passes through a 2-flop synchroniser (d_sync).
- Sample strobe: asserted internally on the clk_i cycle where the divider drives m_clk_o 1->0. The captured bit is d_sync in that cycle.
- Window update per sample:
  - Circular buffer of WINDOW bits with write pointer wp; wp wraps WINDOW-1 -> 0.
  - sum_next = sum - buf[wp] + new; then buf[wp] <= new, wp++.
  - sum never under- or overflows; SW bits hold WINDOW exactly.
- Output timing: sum_o, amp_o and peak_o are registered and update 1 clk_i cycle after the sample strobe. sample_valid_o pulses in that same cycle.
- FSM:
  - FILL: fill counter increments per sample; sample_valid_o is suppressed; full_o = 0. On the WINDOW-th sample, go to RUN.
  - RUN: full_o = 1; sample_valid_o pulses once per sample. The first pulse accompanies the WINDOW-th sample's update.
  - clr_i (any state) -> FILL. Clears buffer, sum, wp, fill count, peak and hold/decay counters. Divider and synchroniser are untouched.
- Simultaneous clr_i and sample strobe: clr_i wins; the sample is discarded and no valid pulse is issued.
- Amplitude: computed from sum_next in the same register stage. No saturation is needed, since WINDOW/2 fits in AW bits.
- Peak, evaluated only on cycles with a sample_valid_o pulse:
  - amp > peak: peak = amp; hold_cnt = HOLD; decay_cnt = 0.
  - else, hold_cnt > 0: hold_cnt--.
  - else: decay_cnt++; on reaching DECAY, decay_cnt = 0 and peak = max(peak-1, amp).
  - peak never drops below the current amp.
- Peak in FILL: peak is frozen at 0.

Optional Feature:
- Macro: PDM_PEAK_HOLD_EN.
- Defined: peak logic exactly as above, with HOLD and DECAY honoured.
- Undefined: no hold or decay counters are built; peak_o is wired to the amp_o register (identical values, same latency).

Test Plan:
- Reset, then release rst_ni -> all outputs 0. First m_clk_o rise at cycle 25; period 50 cycles thereafter; m_lrsel_o = 0 throughout.
- m_data_i constant 1 -> no valid during first 127 samples. With sample 128: sample_valid_o pulse, full_o=1, sum_o=128, amp_o=64, peak_o=64.
- Alternating 1,0 per sample after fill -> sum_o settles at 64, amp_o=0. Peak holds 64 for 4096 samples, then decrements 1 per 256 samples down to 0 (macro defined).
- Full window of 1s, then constant 0 -> sum_o decreases by exactly 1 per sample to 0 after 128 samples. amp_o goes 64 -> 0 (at sum 64) -> 64; wp wrap causes no glitch.
- clr_i asserted in RUN on the same cycle as a sample strobe -> no valid pulse; sum_o=0, peak_o=0, full_o=0 next cycle. m_clk_o continues uninterrupted; next valid only after 128 new samples.
- Build without PDM_PEAK_HOLD_EN, repeat the alternating-pattern scenario -> peak_o equals amp_o every cycle (drops to 0 immediately).
